// File: rtl/mult_pkg.sv
// Shared types and helpers for the Baugh-Wooley multiplier datapath and its accumulate stage.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 4;
    localparam int SEXT_W     = 64;

    // Sign-extend the low 'width' bits of value to SEXT_W; callers truncate to their own width.
    function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] value,
                                                      input int width);
        logic signed [SEXT_W-1:0] shifted;
        shifted = $signed(value << (SEXT_W - width));
        return shifted >>> (SEXT_W - width);
    endfunction

endpackage

// File: rtl/mac_add_ovf.sv
// Combinational wrapping add of a sign-extended product into the accumulator, with signed overflow.
module mac_add_ovf
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] addend;

    assign addend = ACC_W'(sign_extend(SEXT_W'(prod), PROD_W));
    assign sum    = acc + addend;
    // Overflow: both operands share a sign and the wrapped sum does not.
    assign ovf    = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

endmodule

// File: rtl/bw_mac_accum.sv
// Burst accumulator: sums len signed products (len=0 means 2^LEN_W) and hands one result downstream.
module bw_mac_accum
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam int CNT_W = LEN_W + 1;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic             step_ovf;
    logic [CNT_W-1:0] cnt;
    logic             xfer;

    // Handshakes: a word moves on a cycle where valid and ready are both high at the rising edge;
    // in_ready depends only on state, and out_acc/out_ovf hold steady while out_valid waits for out_ready.
    assign xfer = in_valid && in_ready;

    mac_add_ovf #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc (acc),
        .prod(in_prod),
        .sum (sum),
        .ovf (step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Only the start branch clears acc, so the last result stays visible through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= (len == '0) ? (CNT_W'(1) << LEN_W) : CNT_W'(len);
        end else if (xfer) begin
            acc <= sum;
            ovf <= ovf | step_ovf;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_bw_mac_accum.sv
// Bench: drives one stimulus stream into a 16-bit and an 8-bit accumulator and scores both results.
module tb_bw_mac_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_acc;
    logic        out_ovf;
    logic        busy;

    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_acc8;
    logic        out_ovf8;
    logic        busy8;

    logic [16:0] exp16_q[$];
    logic [8:0]  exp8_q[$];
    int          prod_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    bw_mac_accum dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
    );

    bw_mac_accum #(.ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready8), .in_prod(in_prod),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_acc(out_acc8), .out_ovf(out_ovf8), .busy(busy8)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer sum, wrapped into w-bit signed range after every add.
    function automatic longint model(input int w, output bit ovf);
        longint acc, t, lo, hi, span;
        span = longint'(1) << w;
        hi   = (span >> 1) - 1;
        lo   = -(span >> 1);
        acc  = 0;
        ovf  = 1'b0;
        foreach (prod_q[k]) begin
            t = acc + prod_q[k];
            if (t > hi || t < lo) ovf = 1'b1;
            if (t > hi) t -= span;
            if (t < lo) t += span;
            acc = t;
        end
        return acc;
    endfunction

    // Scoreboard monitor: pops on each output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp16_q.size() == 0) check("acc16_unexpected_result", 1, 0);
            else check("acc16_result", {out_ovf, out_acc}, exp16_q.pop_front());
        end
        if (rst_n && out_valid8 && out_ready) begin
            if (exp8_q.size() == 0) check("acc8_unexpected_result", 1, 0);
            else check("acc8_result", {out_ovf8, out_acc8}, exp8_q.pop_front());
        end
    end

    task automatic fill_random(input int n);
        logic [7:0] b;
        prod_q.delete();
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            prod_q.push_back(int'($signed(b)));
        end
    endtask

    task automatic do_burst(input int n_len, input int gap, input int hold,
                            input bit start_in_accum, input bit start_in_done);
        int          n, i, budget;
        bit          ovf16, ovf8, acc_ok, fresh;
        logic [16:0] e16;
        logic [8:0]  e8;
        n   = (n_len == 0) ? 16 : n_len;
        e16 = {ovf16, 16'(model(16, ovf16))};
        e8  = {ovf8, 8'(model(8, ovf8))};
        e16[16] = ovf16;
        e8[8]   = ovf8;
        exp16_q.push_back(e16);
        exp8_q.push_back(e8);

        start = 1'b1;
        len = 4'(n_len);
        out_ready = 1'b0;
        step();
        start = 1'b0;
        len = 4'($urandom_range(0, 15));
        check("start_to_in_ready", in_ready, 1);
        check("busy_in_accum", busy, 1);

        i = 0;
        budget = 0;
        fresh = 1'b0;
        while (i < n && budget < 400) begin
            if (fresh && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) step();
                budget += gap;
            end
            fresh = 1'b0;
            in_valid = 1'b1;
            in_prod = 8'(prod_q[i]);
            if (start_in_accum && i == n / 2) begin
                start = 1'b1;
                len = 4'd1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc_ok = in_valid && in_ready;
            step();
            start = 1'b0;
            out_ready = 1'b0;
            budget++;
            if (acc_ok) begin
                i++;
                fresh = 1'b1;
            end
        end
        check("products_accepted", i, n);

        check("done_out_valid_latency", out_valid, 1);
        check("done_in_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_prod = 8'($urandom_range(0, 255));
        repeat (hold) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_acc", out_acc, e16[15:0]);
            check("hold_out_ovf", out_ovf, e16[16]);
            check("hold_extra_product_refused", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        start = start_in_done;
        len = 4'd1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("idle_after_handshake_busy", busy, 0);
        check("idle_after_handshake_busy8", busy8, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_keeps_out_acc", out_acc, e16[15:0]);
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_in_ready_low", in_ready, 0);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len = 4'd0;
        in_valid = 1'b0;
        in_prod = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_acc", out_acc, 0);
        check("reset_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset in the middle of a burst after one accepted product
        start = 1'b1;
        len = 4'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_prod = 8'h22;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_acc", out_acc, 0);
        check("midreset_out_ovf", out_ovf, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_out_valid", out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) step();
        check("post_reset_in_ready", in_ready, 0);
        check("post_reset_busy", busy, 0);
        in_valid = 1'b0;

        prod_q = '{64, -56, 15};
        do_burst(3, 0, 0, 1'b0, 1'b0);

        prod_q = '{-8, -8};
        do_burst(2, 3, 4, 1'b0, 1'b0);

        prod_q = '{64, 64};
        do_burst(2, 0, 1, 1'b0, 1'b0);
        prod_q = '{1};
        do_burst(1, 0, 1, 1'b0, 1'b0);

        prod_q.delete();
        repeat (16) prod_q.push_back(64);
        do_burst(0, 0, 2, 1'b0, 1'b0);

        fill_random(5);
        do_burst(5, 0, 1, 1'b1, 1'b1);

        for (int b = 0; b < 25; b++) begin
            int l;
            l = $urandom_range(0, 15);
            fill_random((l == 0) ? 16 : l);
            do_burst(l, $urandom_range(0, 2), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (2) step();
        check("acc16_queue_drained", exp16_q.size(), 0);
        check("acc8_queue_drained", exp8_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bw_mac_accum.md
Name: bw_mac_accum

Overview:
- Signed accumulate stage directly downstream of the 4-bit Baugh-Wooley multiplier.
- Consumes a burst of 8-bit two's-complement products over a valid/ready handshake.
- Sums the burst into a wider accumulator, flagging signed overflow.
- Presents one result per burst to the next stage over a second valid/ready handshake.

Parameters:
- PROD_W, 8, width of incoming signed product.
- ACC_W, 16, accumulator/result width; must be >= PROD_W.
- LEN_W, 4, width of burst-length field; len=0 means 2^LEN_W products.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a burst (honoured only in IDLE).
- len  input  LEN_W  number of products in the burst, sampled with start.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  stage accepts a product this cycle.
- in_prod  input  PROD_W  signed product from the multiplier.
- out_valid  output  1  out_acc/out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed burst sum.
- out_ovf  output  1  sticky signed-overflow flag for the burst.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset is asynchronous and active-low and may occur at any time, including mid-burst. Reset values:
  - state=IDLE
  - acc=0, cnt=0, ovf=0
  - in_ready=0, out_valid=0, busy=0
  - out_acc=0, out_ovf=0
- States:
  - IDLE: in_ready=0, out_valid=0. On start=1: acc<=0, ovf<=0, cnt<=(len==0 ? 2^LEN_W : len), go to ACCUM. Products offered in IDLE are not accepted.
  - ACCUM: in_ready=1.
    - A transfer occurs when in_valid & in_ready.
    - On each transfer: acc <= acc + sign_extend(in_prod, ACC_W), wrapping modulo 2^ACC_W. ovf <= ovf | signed_overflow(acc, sext(in_prod)). cnt <= cnt-1.
    - Transfer with cnt==1 → DONE next cycle.
    - No transfer → hold all state. No timeout.
  - DONE: in_ready=0, out_valid=1. out_acc=acc and out_ovf=ovf, held stable until handshake. On out_ready=1 → IDLE next cycle.
- out_acc/out_ovf are registered and driven directly from acc/ovf. They keep their last value in IDLE.
- Signed overflow: operands of equal sign whose sum has the opposite sign. Once set, ovf stays set for the rest of the burst.
- Latency:
  - start → in_ready high: 1 cycle.
  - Last product accepted → out_valid high: 1 cycle.
  - Minimum burst of N products: N+2 cycles from start to result, with in_valid held high and out_ready=1.
- start in ACCUM or DONE is ignored. This includes DONE with out_ready=1 in the same cycle: the burst completes and start must be reissued in IDLE.
- len is sampled only with an honoured start. Changes afterwards have no effect.
- busy = (state != IDLE).
- out_ready while not in DONE has no effect.

Decomposition:
- Shared package (mult_pkg):
  - state enum {IDLE, ACCUM, DONE}
  - default width constants PROD_W=8, ACC_W=16, LEN_W=4
  - sign-extension helper function
- One natural sub-module, mac_add_ovf:
  - inputs: ACC_W accumulator, PROD_W addend
  - outputs: wrapped sum and overflow bit
  - purely combinational

Test Plan:
1. Reset mid-burst: start, len=3, accept 1 product, assert rst_n=0 → all outputs 0, state IDLE. After release, in_ready stays 0 until the next start.
2. Basic burst: start, len=3; products 8'h40(+64), 8'hC8(-56), 8'h0F(+15) back-to-back → out_valid 1 cycle after the third transfer, out_acc=16'h0017, out_ovf=0.
3. Backpressure and gaps: len=2 with an in_valid gap of 3 cycles; then hold out_ready=0 for 4 cycles in DONE → out_acc=16'hFFF0 for products 8'hF8, 8'hF8, stable throughout; IDLE 1 cycle after out_ready=1.
4. Overflow with ACC_W=8: len=2, products 8'h40, 8'h40 → out_acc=8'h80, out_ovf=1. A further burst len=1, product 8'h01 → out_ovf=0, out_acc=8'h01.
5. len=0: start with len=0, 16 products of 8'h40 → exactly 16 transfers accepted, out_acc=16'h0400, out_ovf=0. A 17th offered product is not accepted.
6. Ignored start: pulse start with len=1 during ACCUM and again during DONE together with out_ready=1 → burst length unchanged, block returns to IDLE, busy=0.
